// File: rtl/audio_frame_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module   : audio_frame_streamer_if
//  Purpose  : Word stream from the audio frame streamer toward the FFT input
//             stage (data, valid/ready handshake and end-of-pass marker).
//  Revision : 1.0 - initial release
// ============================================================================
interface audio_frame_streamer_if #(
   parameter int INPUT_SIZE = 512
);
   logic [INPUT_SIZE-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface
`default_nettype wire

// File: rtl/audio_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : audio_frame_streamer
//  Purpose  : Walks the audio storage block from word 0 to NUM_WORDS-1 and
//             streams each word, registered, to the FFT input stage with a
//             valid/ready handshake. One word per cycle when not stalled.
//  Options  : STREAM_LOOP_EN - when defined, the pass restarts at word 0
//             without a bubble after the last word; only abort or reset
//             stop the stream.
//  Revision : 1.0 - initial release
// ============================================================================
module audio_frame_streamer #(
   parameter int INPUT_SIZE = 512,
   parameter int NUM_WORDS  = 4096,
   parameter int IDX_W      = $clog2(NUM_WORDS)
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   input  wire logic                  start,
   input  wire logic                  abort,
   output logic [IDX_W-1:0]           rd_idx,
   input  wire logic [INPUT_SIZE-1:0] word_in,
   audio_frame_streamer_if.master     m_out,
   output logic                       busy,
   output logic                       done,
   output logic [IDX_W:0]             word_count
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_FETCH = 2'd1;
   localparam logic [1:0] c_SEND  = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [IDX_W:0]   c_CNT_ONE  = (IDX_W+1)'(1);

   logic [1:0]            r_state;
   logic [IDX_W-1:0]      r_rd_idx;
   logic [INPUT_SIZE-1:0] r_out_data;
   logic                  r_out_valid;
   logic                  r_out_last;
   logic                  r_done;
   logic [IDX_W:0]        r_word_count;

   logic                  w_xfer;
   logic                  w_at_last;
   logic [IDX_W-1:0]      w_next_idx;

   // Handshake and next read index; the index wraps explicitly so that a
   // non power-of-two NUM_WORDS still returns to word 0.
   always_comb begin
      w_xfer     = r_out_valid & m_out.out_ready;
      w_at_last  = (r_rd_idx == c_LAST_IDX);
      w_next_idx = w_at_last ? '0 : r_rd_idx + 1'b1;
   end

   // Pass sequencer: fetch the first word, then reload the output register
   // on every accepted transfer so back-to-back words need no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= c_IDLE;
         r_rd_idx     <= '0;
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
         r_done       <= 1'b0;
         r_word_count <= '0;
      end else if (abort) begin
         // Abort wins over start and over a transfer in the same cycle;
         // the word on the bus that cycle is not counted.
         r_state     <= c_IDLE;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_state      <= c_FETCH;
                  r_rd_idx     <= '0;
                  r_word_count <= '0;
               end
            end
            c_FETCH: begin
               r_out_data  <= word_in;
               r_out_last  <= w_at_last;
               r_rd_idx    <= w_next_idx;
               r_out_valid <= 1'b1;
               r_state     <= c_SEND;
            end
            c_SEND: begin
               if (w_xfer) begin
                  if (r_out_last) begin
`ifdef STREAM_LOOP_EN
                     // rd_idx already wrapped to 0: word 0 of the next pass
                     // is loaded while the pass-complete pulse is raised.
                     r_out_data   <= word_in;
                     r_out_last   <= w_at_last;
                     r_rd_idx     <= w_next_idx;
                     r_word_count <= c_CNT_ONE;
                     r_done       <= 1'b1;
`else
                     r_word_count <= r_word_count + 1'b1;
                     r_out_valid  <= 1'b0;
                     r_out_last   <= 1'b0;
                     r_done       <= 1'b1;
                     r_state      <= c_DONE;
`endif
                  end else begin
                     r_word_count <= r_word_count + 1'b1;
                     r_out_data   <= word_in;
                     r_out_last   <= w_at_last;
                     r_rd_idx     <= w_next_idx;
                  end
               end
            end
            c_DONE: begin
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   // Output mapping
   always_comb begin
      rd_idx          = r_rd_idx;
      m_out.out_data  = r_out_data;
      m_out.out_valid = r_out_valid;
      m_out.out_last  = r_out_last;
      busy            = (r_state == c_FETCH) || (r_state == c_SEND);
      done            = r_done;
      word_count      = r_word_count;
   end

endmodule
`default_nettype wire
